// File: rtl/err_mon_pkg.sv
// Shared types and helpers for the error-sum window monitor.
package err_mon_pkg;

  localparam int unsigned DEF_INWIDTH  = 26;
  localparam int unsigned DEF_ACCWIDTH = 32;
  localparam int unsigned DEF_WIN_LEN  = 8;
  localparam int unsigned DEF_TRIP_CNT = 3;

  // Widest accumulator the saturating adder supports.
  localparam int unsigned SAT_MAXW = 64;
  localparam int unsigned SAT_W1   = SAT_MAXW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  // Unsigned add clamped to the all-ones value of a w-bit result.
  function automatic logic [SAT_MAXW-1:0] sat_add(input logic [SAT_MAXW-1:0] a,
                                                  input logic [SAT_MAXW-1:0] b,
                                                  input int unsigned         w);
    logic [SAT_MAXW:0] sum;
    logic [SAT_MAXW:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (SAT_W1'(1) << w) - SAT_W1'(1);
    return (sum > lim) ? lim[SAT_MAXW-1:0] : sum[SAT_MAXW-1:0];
  endfunction

endpackage

// File: rtl/err_sum_window_monitor_if.sv
// Bus between the upstream error sum-up stage / control logic and the window monitor.
interface err_sum_window_monitor_if #(
  parameter int unsigned INWIDTH  = 26,
  parameter int unsigned ACCWIDTH = 32,
  parameter int unsigned TRIP_CNT = 3
);
  localparam int unsigned TCW = $clog2(TRIP_CNT + 1);

  logic [INWIDTH-1:0]  err_chk_sumup_i;
  logic                err_chk_sumup_en_i;
  logic [ACCWIDTH-1:0] thresh_i;
  logic                clear_i;
  logic [ACCWIDTH-1:0] win_sum_o;
  logic                win_done_o;
  logic                win_exceed_o;
  logic [TCW-1:0]      trip_cnt_o;
  logic                fault_o;

  modport master (
    output err_chk_sumup_i, err_chk_sumup_en_i, thresh_i, clear_i,
    input  win_sum_o, win_done_o, win_exceed_o, trip_cnt_o, fault_o
  );

  modport slave (
    input  err_chk_sumup_i, err_chk_sumup_en_i, thresh_i, clear_i,
    output win_sum_o, win_done_o, win_exceed_o, trip_cnt_o, fault_o
  );
endinterface

// File: rtl/err_win_accum.sv
// Saturating window accumulator with sample counter; flags the closing sample
// and presents the saturated window total combinationally.
module err_win_accum
  import err_mon_pkg::*;
#(
  parameter int unsigned INWIDTH  = DEF_INWIDTH,
  parameter int unsigned ACCWIDTH = DEF_ACCWIDTH,
  parameter int unsigned WIN_LEN  = DEF_WIN_LEN
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic [INWIDTH-1:0]  i_sample,
  output logic                o_close_c,
  output logic [ACCWIDTH-1:0] o_total_c
);

  localparam int unsigned CNTW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  logic [ACCWIDTH-1:0] r_acc;
  logic [CNTW-1:0]     r_cnt;
  logic [ACCWIDTH-1:0] w_sum;
  logic                w_last;

  assign w_sum     = ACCWIDTH'(sat_add(SAT_MAXW'(r_acc), SAT_MAXW'(i_sample), ACCWIDTH));
  assign w_last    = (r_cnt == CNTW'(WIN_LEN - 1));
  assign o_close_c = i_en & w_last & ~i_clear;
  assign o_total_c = w_sum;

  // Restart on the closing sample so the next window begins on the next en.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/err_sum_window_monitor.sv
// Windowed error-sum monitor: compares each window total against a threshold
// and raises a sticky fault after TRIP_CNT consecutive exceeding windows.
module err_sum_window_monitor
  import err_mon_pkg::*;
#(
  parameter int unsigned INWIDTH  = DEF_INWIDTH,
  parameter int unsigned ACCWIDTH = DEF_ACCWIDTH,
  parameter int unsigned WIN_LEN  = DEF_WIN_LEN,
  parameter int unsigned TRIP_CNT = DEF_TRIP_CNT
) (
  input  logic                     clk,
  input  logic                     rstn,
  err_sum_window_monitor_if.slave  mon_if
);

  localparam int unsigned TCW = $clog2(TRIP_CNT + 1);

  mon_state_e          r_state, w_state_nxt;
  logic [ACCWIDTH-1:0] r_win_sum, w_win_sum_nxt;
  logic                r_win_done, w_win_done_nxt;
  logic                r_win_exceed, w_win_exceed_nxt;
  logic [TCW-1:0]      r_trip, w_trip_nxt, w_trip_inc;
  logic                r_fault, w_fault_nxt;
  logic                w_close;
  logic [ACCWIDTH-1:0] w_total;
  logic                w_exceed;

  err_win_accum #(
    .INWIDTH  (INWIDTH),
    .ACCWIDTH (ACCWIDTH),
    .WIN_LEN  (WIN_LEN)
  ) u_accum (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (mon_if.clear_i),
    .i_en      (mon_if.err_chk_sumup_en_i),
    .i_sample  (mon_if.err_chk_sumup_i),
    .o_close_c (w_close),
    .o_total_c (w_total)
  );

  assign w_exceed   = (w_total > mon_if.thresh_i);
  assign w_trip_inc = (r_trip == TCW'(TRIP_CNT)) ? r_trip : r_trip + TCW'(1);

  // Next-state and next-output logic; clear overrides everything except the held window result.
  always_comb begin
    w_state_nxt      = r_state;
    w_win_sum_nxt    = r_win_sum;
    w_win_done_nxt   = 1'b0;
    w_win_exceed_nxt = r_win_exceed;
    w_trip_nxt       = r_trip;
    w_fault_nxt      = r_fault;

    if (mon_if.clear_i) begin
      w_state_nxt = ST_IDLE;
      w_trip_nxt  = '0;
      w_fault_nxt = 1'b0;
    end else begin
      if (w_close) begin
        w_win_done_nxt   = 1'b1;
        w_win_sum_nxt    = w_total;
        w_win_exceed_nxt = w_exceed;
        w_trip_nxt       = w_exceed ? w_trip_inc : '0;
        if (w_exceed && (w_trip_inc == TCW'(TRIP_CNT))) begin
          w_fault_nxt = 1'b1;
        end
      end

      unique case (r_state)
        ST_IDLE: begin
          if (mon_if.err_chk_sumup_en_i) begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_close) begin
            w_state_nxt = w_fault_nxt ? ST_FAULT : ST_IDLE;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win_sum    <= '0;
      r_win_done   <= 1'b0;
      r_win_exceed <= 1'b0;
      r_trip       <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_win_sum    <= w_win_sum_nxt;
      r_win_done   <= w_win_done_nxt;
      r_win_exceed <= w_win_exceed_nxt;
      r_trip       <= w_trip_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  assign mon_if.win_sum_o    = r_win_sum;
  assign mon_if.win_done_o   = r_win_done;
  assign mon_if.win_exceed_o = r_win_exceed;
  assign mon_if.trip_cnt_o   = r_trip;
  assign mon_if.fault_o      = r_fault;

endmodule
